// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer: FSM encoding, operation codes and
// default latencies of the attached multiply/divide units.
package hilo_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_MULT_LAT = 33;
  localparam int unsigned DEF_DIV_LAT  = 34;
  localparam int unsigned DEF_CNT_W    = 6;

  // Counter preload: the LAUNCH cycle itself accounts for one cycle of latency.
  function automatic int unsigned lat_load(input logic op,
                                           input int unsigned mult_lat,
                                           input int unsigned div_lat);
    return (op == OP_DIV) ? div_lat - 1 : mult_lat - 1;
  endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// Bundle of control-unit and mult/div-unit signals around the HI/LO sequencer.
// slave is the sequencer view; master is the surrounding environment.
interface hilo_ctrl_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] value_A;
  logic [WIDTH-1:0] value_B;
  logic             abort;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mult_init;
  logic             div_init;
  logic             unit_rst;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  start, op_div, value_A, value_B, abort, hi_we, lo_we, wdata,
           mult_hi, mult_lo, div_hi, div_lo,
    output op_a, op_b, mult_init, div_init, unit_rst, busy, done, div_zero,
           hi, lo
  );

  modport master (
    output start, op_div, value_A, value_B, abort, hi_we, lo_we, wdata,
           mult_hi, mult_lo, div_hi, div_lo,
    input  op_a, op_b, mult_init, div_init, unit_rst, busy, done, div_zero,
           hi, lo
  );

endinterface

// File: rtl/hilo_regs.sv
// Architectural HI/LO pair: unit-result capture has priority over mthi/mtlo writes.
// Division results land swapped: quotient to LO, remainder to HI.
module hilo_regs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             cap_div,
  input  logic             wr_en,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
    end else if (capture) begin
      hi <= cap_div ? div_lo : mult_hi;
    end else if (wr_en && hi_we) begin
      hi <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo <= '0;
    end else if (capture) begin
      lo <= cap_div ? div_hi : mult_lo;
    end else if (wr_en && lo_we) begin
      lo <= wdata;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// Sequencer for the multi-cycle mult/div units: latches operands, launches a unit,
// counts its fixed latency and captures the result into HI/LO.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  hilo_ctrl_if.slave bus
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic             dz_q;
  logic             unit_rst_q;
  logic             accept;
  logic             is_dz;
  int unsigned      ld;

  logic             busy;
  logic             done;
  logic             div_zero;
  logic             mult_init;
  logic             div_init;
  logic             capture;
  logic             wr_en;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  assign accept = (state == S_IDLE) && bus.start && !bus.abort;
  assign is_dz  = bus.op_div && (bus.value_B == '0);
  assign ld     = lat_load(op_q, MULT_LAT, DIV_LAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (bus.abort) begin
      next_state = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:    if (bus.start) next_state = is_dz ? S_DONE : S_LAUNCH;
        S_LAUNCH:  next_state = S_WAIT;
        S_WAIT:    if (cnt == '0) next_state = S_CAPTURE;
        S_CAPTURE: next_state = S_DONE;
        S_DONE:    next_state = S_IDLE;
        default:   next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_CAPTURE);
    done      = (state == S_DONE);
    div_zero  = (state == S_DONE) && dz_q;
    mult_init = (state == S_LAUNCH) && (op_q == OP_MULT);
    div_init  = (state == S_LAUNCH) && (op_q == OP_DIV);
    capture   = (state == S_CAPTURE) && !bus.abort;
    wr_en     = (state == S_IDLE) && !bus.abort;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_MULT;
      dz_q <= 1'b0;
    end else if (accept) begin
      a_q  <= bus.value_A;
      b_q  <= bus.value_B;
      op_q <= bus.op_div;
      dz_q <= is_dz;
    end
  end

  // The preload must fit CNT_W bits, otherwise the latency count silently wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == S_LAUNCH) begin
      assert (ld < (32'd1 << CNT_W));
      cnt <= CNT_W'(ld);
    end else if ((state == S_WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unit_rst_q <= 1'b1;
    end else begin
      unit_rst_q <= bus.abort;
    end
  end

  hilo_regs #(
    .WIDTH (WIDTH)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .capture (capture),
    .cap_div (op_q),
    .wr_en   (wr_en),
    .hi_we   (bus.hi_we),
    .lo_we   (bus.lo_we),
    .wdata   (bus.wdata),
    .mult_hi (bus.mult_hi),
    .mult_lo (bus.mult_lo),
    .div_hi  (bus.div_hi),
    .div_lo  (bus.div_lo),
    .hi      (hi_r),
    .lo      (lo_r)
  );

  assign bus.op_a      = a_q;
  assign bus.op_b      = b_q;
  assign bus.mult_init = mult_init;
  assign bus.div_init  = div_init;
  assign bus.unit_rst  = unit_rst_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.div_zero  = div_zero;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;

endmodule
